// File: rtl/hbf_phase_merge.sv
// rtl/hbf_phase_merge.sv - polyphase pair FIFO with top/bottom interleaved output
module hbf_phase_merge #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_sample_top,
    input  logic [DATA_WIDTH-1:0]         in_sample_bottom,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_sample,
    output logic                          out_phase,
    output logic [$clog2(FIFO_DEPTH):0]   pairs_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        PH_TOP    = 1'b0,
        PH_BOTTOM = 1'b1
    } phase_t;

    // Pair storage: each entry holds the even and odd sample of one pair.
    logic [DATA_WIDTH-1:0] r_mem_top [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_bot [FIFO_DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    phase_t        r_phase;
    phase_t        w_phase_next;

    logic          w_push;
    logic          w_pop;
    logic          w_out_fire;
    logic          w_not_empty;

    // Readiness comes only from registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready    = (r_count != CW'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign out_valid   = w_not_empty;
    assign w_push      = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;

    // Head sample selected by phase; gated to zero when empty so reset shows a clean output.
    assign out_sample    = !w_not_empty           ? '0 :
                           (r_phase == PH_BOTTOM) ? r_mem_bot[r_rd_ptr] :
                                                    r_mem_top[r_rd_ptr];
    assign out_phase     = (r_phase == PH_BOTTOM);
    assign pairs_pending = r_count;

    // Next phase and head pop: the head entry retires only once its bottom sample is taken.
    always_comb begin
        w_phase_next = r_phase;
        w_pop        = 1'b0;
        case (r_phase)
            PH_TOP: begin
                if (w_out_fire) begin
                    w_phase_next = PH_BOTTOM;
                end
            end
            PH_BOTTOM: begin
                if (w_out_fire) begin
                    w_phase_next = PH_TOP;
                    w_pop        = 1'b1;
                end
            end
            default: begin
                w_phase_next = PH_TOP;
            end
        endcase
    end

    // Phase register; reset discards any half-emitted pair by returning to the top phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_TOP;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pair write; storage contents need no reset because output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_top[r_wr_ptr] <= in_sample_top;
            r_mem_bot[r_wr_ptr] <= in_sample_bottom;
        end
    end

endmodule

// File: tb/tb_hbf_phase_merge.sv
// tb/tb_hbf_phase_merge.sv - scoreboard bench for hbf_phase_merge
module tb_hbf_phase_merge;

    localparam int DW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sample_top;
    logic [DW-1:0] in_sample_bottom;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic          out_phase;
    logic [$clog2(FD):0] pairs_pending;

    int n_total = 0;
    int n_bad   = 0;
    logic [DW:0] sb [$];

    hbf_phase_merge #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sample_top   (in_sample_top),
        .in_sample_bottom(in_sample_bottom),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sample      (out_sample),
        .out_phase       (out_phase),
        .pairs_pending   (pairs_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare each output handshake, then record accepted pairs.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("out_unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    chk("out_stream", 32'({out_phase, out_sample}), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({1'b0, in_sample_top});
                sb.push_back({1'b1, in_sample_bottom});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [DW-1:0] t, input logic [DW-1:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_sample_top = t;
        in_sample_bottom = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        int acc_n;
        logic rnd_done;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample_top = '0;
        in_sample_bottom = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_phase", 32'(out_phase), 32'd0);
        chk("rst_pending", 32'(pairs_pending), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Basic interleave and first-valid latency.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sample_top = 16'h0001;
        in_sample_bottom = 16'h0002;
        @(negedge clk);
        chk("lat_push_cycle_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_next_valid", 32'(out_valid), 32'd1);
        chk("lat_next_sample", 32'(out_sample), 32'h0001);
        in_sample_top = 16'h0003;
        in_sample_bottom = 16'h0004;
        step();
        in_valid = 1'b0;
        drain();

        // Backpressure holds the top sample stable.
        out_ready = 1'b0;
        push_pair(16'h1111, 16'h2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sample", 32'(out_sample), 32'h1111);
            chk("bp_phase", 32'(out_phase), 32'd0);
        end
        step();
        drain();

        // Full: six attempts, four accepted.
        out_ready = 1'b0;
        acc_n = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_sample_top = 16'h0100 + 16'(k);
            in_sample_bottom = 16'h0200 + 16'(k);
            @(negedge clk);
            if (k >= 4) chk("full_in_ready_low", 32'(in_ready), 32'd0);
            if (in_ready) acc_n++;
            step();
        end
        chk("full_accepted", 32'(acc_n), 32'd4);
        chk("full_pending", 32'(pairs_pending), 32'd4);
        in_sample_top = 16'h0104;
        in_sample_bottom = 16'h0204;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_top_drain_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("full_bot_drain_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("full_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        drain();

        // Simultaneous push and pop at two pending pairs.
        out_ready = 1'b0;
        push_pair(16'h0A01, 16'h0B01);
        push_pair(16'h0A02, 16'h0B02);
        chk("sim_pending_before", 32'(pairs_pending), 32'd2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        in_sample_top = 16'h0A03;
        in_sample_bottom = 16'h0B03;
        @(negedge clk);
        chk("sim_phase_bottom", 32'(out_phase), 32'd1);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("sim_pending_after", 32'(pairs_pending), 32'd2);
        drain();

        // Mid-pair reset discards the bottom half.
        out_ready = 1'b0;
        push_pair(16'hAAAA, 16'h5555);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_phase", 32'(out_phase), 32'd0);
        chk("mid_rst_pending", 32'(pairs_pending), 32'd0);
        chk("mid_rst_sample", 32'(out_sample), 32'd0);
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        push_pair(16'h0007, 16'h0008);
        chk("post_rst_first", 32'(out_sample), 32'h0007);
        drain();

        // Random stream with random backpressure, exercises pointer wrap.
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    push_pair(16'($urandom), 16'($urandom));
                    if ($urandom_range(0, 2) == 0) step();
                end
                rnd_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !rnd_done; c++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
